// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, handler entry
// and the handler-state type used by cp0_unit and its interface.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_ENTRY = 32'h0000_4180;
  localparam logic [31:0] SR_WMASK      = 32'h0000_FC03;

  // Handler state is exactly SR.EXL: IDLE <-> EXL=0, IN_HANDLER <-> EXL=1.
  typedef enum logic {
    ST_IDLE       = 1'b0,
    ST_IN_HANDLER = 1'b1
  } cp0_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cp0_if.sv
// M-stage CP0 control/data bundle between the pipeline (master) and cp0_unit (slave).
// Strobes we/eret/exc_in are single-cycle qualifiers with no ready: CP0 always accepts.
interface cp0_if;
  import cp0_pkg::*;

  logic [4:0]  A;
  logic [31:0] DIn;
  logic        we;
  logic        eret;
  logic [5:0]  exc_in;
  logic [31:0] PC;
  logic        BD;
  logic [5:0]  HWInt;
  logic        IntReq;
  logic [31:0] EPC_out;
  logic [31:0] DOut;
  cp0_state_e  state_dbg;

  modport master (
    output A, DIn, we, eret, exc_in, PC, BD, HWInt,
    input  IntReq, EPC_out, DOut, state_dbg
  );

  modport slave (
    input  A, DIn, we, eret, exc_in, PC, BD, HWInt,
    output IntReq, EPC_out, DOut, state_dbg
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0: SR/Cause/EPC/PRId, interrupt vs exception arbitration and the
// same-cycle IntReq back to the PC logic (which redirects to HANDLER_ENTRY).
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h2019_0001
) (
  input  logic  clk,
  input  logic  reset,
  cp0_if.slave  bus
);

  cp0_state_e  state_q, state_d;
  logic [5:0]  im_q, im_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        exl;
  logic        int_pend;
  logic        exc_pend;
  logic        int_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      im_q       <= '0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      state_q    <= state_d;
      im_q       <= im_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    exl        = (state_q == ST_IN_HANDLER);
    int_pend   = (|(bus.HWInt & im_q)) & ie_q & ~exl;
    exc_pend   = bus.exc_in[5] & ~exl;
    int_req    = int_pend | exc_pend;

    state_d    = state_q;
    im_d       = im_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    // IP is a plain level sample of the lines; nothing else touches it.
    ip_d       = bus.HWInt;

    // A taken request swallows any same-cycle eret or mtc0.
    if (int_req) begin
      state_d    = ST_IN_HANDLER;
      bd_d       = bus.BD;
      exc_code_d = int_pend ? EXC_INT : bus.exc_in[4:0];
      epc_d      = bus.BD ? (word_align(bus.PC) - 32'd4) : word_align(bus.PC);
    end else if (bus.eret) begin
      state_d = ST_IDLE;
    end else if (bus.we) begin
      case (bus.A)
        CP0_SR: begin
          im_d    = bus.DIn[15:10];
          ie_d    = bus.DIn[0];
          state_d = bus.DIn[1] ? ST_IN_HANDLER : ST_IDLE;
        end
        CP0_EPC: epc_d = word_align(bus.DIn);
        default: ;
      endcase
    end
  end

  always_comb begin
    sr_word    = {16'b0, im_q, 8'b0, exl, ie_q} & SR_WMASK;
    cause_word = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
    case (bus.A)
      CP0_SR:    bus.DOut = sr_word;
      CP0_CAUSE: bus.DOut = cause_word;
      CP0_EPC:   bus.DOut = epc_q;
      CP0_PRID:  bus.DOut = PRID;
      default:   bus.DOut = 32'b0;
    endcase
  end

  assign bus.IntReq    = int_req;
  assign bus.EPC_out   = epc_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios followed by randomized traffic, all
// checked every cycle against a word-level model of SR/Cause/EPC.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h2019_0001;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  cp0_if bus();

  cp0_unit #(.PRID(PRID)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model
  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_int_pend();
    return ((bus.HWInt & m_sr[15:10]) != 6'b0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int_pend() || (bus.exc_in[5] && !m_sr[1]);
  endfunction

  task automatic model_edge();
    logic ip;
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      ip = m_int_pend();
      m_cause[15:10] = bus.HWInt;
      if (m_req()) begin
        m_sr[1]       = 1'b1;
        m_cause[31]   = bus.BD;
        m_cause[6:2]  = ip ? 5'd0 : bus.exc_in[4:0];
        m_epc         = (bus.PC & ~32'd3) - (bus.BD ? 32'd4 : 32'd0);
      end else if (bus.eret) begin
        m_sr[1] = 1'b0;
      end else if (bus.we) begin
        if (bus.A == 5'd12) m_sr = bus.DIn & 32'h0000_FC03;
        else if (bus.A == 5'd14) m_epc = bus.DIn & ~32'd3;
      end
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    bus.A = 5'd0; bus.DIn = 32'h0; bus.we = 1'b0; bus.eret = 1'b0;
    bus.exc_in = 6'b0; bus.PC = 32'h0; bus.BD = 1'b0; bus.HWInt = 6'b0;
    reset = 1'b0;
  endtask

  // Compare outputs mid-cycle, then advance one edge and update the model.
  task automatic step();
    @(negedge clk);
    check("int_req", 32'(bus.IntReq), 32'(m_req()));
    check("epc_out", bus.EPC_out, m_epc);
    check("dout", bus.DOut, m_read(bus.A));
    check("state", 32'(bus.state_dbg), 32'(m_sr[1]));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic peek(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check(tag, obs, exp);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_sr = 32'hFFFF_FFFF; m_cause = 32'hFFFF_FFFF; m_epc = 32'hFFFF_FFFF;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); model_edge();
    @(posedge clk); model_edge();
    #1;
    reset = 1'b0;

    // reset state
    bus.A = 5'd12; #1 peek("rst_sr", bus.DOut, 32'h0);
    peek("rst_intreq", 32'(bus.IntReq), 32'h0);
    peek("rst_epc", bus.EPC_out, 32'h0);
    step();
    bus.A = 5'd13; #1 peek("rst_cause", bus.DOut, 32'h0);
    step();

    // RI exception from reset state
    bus.exc_in = 6'b1_01010; bus.PC = 32'h3010; bus.BD = 1'b0;
    #1 peek("ri_intreq", 32'(bus.IntReq), 32'h1);
    step();
    idle_inputs(); bus.A = 5'd13;
    #1 peek("ri_exccode", (bus.DOut >> 2) & 32'h1F, 32'd10);
    peek("ri_epc", bus.EPC_out, 32'h3010);
    peek("ri_exl", 32'(bus.state_dbg), 32'h1);
    peek("ri_intreq_after", 32'(bus.IntReq), 32'h0);
    step();
    bus.eret = 1'b1; step(); idle_inputs();

    // enable interrupts, raise HW line 2
    bus.we = 1'b1; bus.A = 5'd12; bus.DIn = 32'h0000_FC01; step();
    idle_inputs(); bus.HWInt = 6'b000100;
    #1 peek("hw_intreq", 32'(bus.IntReq), 32'h1);
    step();
    bus.A = 5'd13;
    #1 peek("hw_cause", bus.DOut, 32'h0000_1000);
    peek("hw_exl", 32'(bus.state_dbg), 32'h1);
    step();
    bus.HWInt = 6'b0; step();
    bus.eret = 1'b1; step(); idle_inputs();

    // exception in a delay slot
    bus.exc_in = 6'b1_00100; bus.PC = 32'h3024; bus.BD = 1'b1; step();
    idle_inputs(); bus.A = 5'd14;
    #1 peek("bd_epc", bus.DOut, 32'h3020);
    step();
    bus.A = 5'd13;
    #1 peek("bd_cause31", bus.DOut >> 31, 32'h1);
    bus.eret = 1'b1;
    #1 peek("eret_epc_out", bus.EPC_out, 32'h3020);
    step(); idle_inputs();
    #1 peek("eret_exl", 32'(bus.state_dbg), 32'h0);
    step();

    // interrupt beats overflow exception
    bus.HWInt = 6'b000001; bus.exc_in = 6'b1_01100; bus.PC = 32'h4000; step();
    idle_inputs(); bus.A = 5'd13;
    #1 peek("prio_exccode", (bus.DOut >> 2) & 32'h1F, 32'd0);
    step();
    bus.eret = 1'b1; step(); idle_inputs();

    // mtc0 EPC dropped under a simultaneous exception
    bus.we = 1'b1; bus.A = 5'd14; bus.DIn = 32'hDEAD_BEEF;
    bus.exc_in = 6'b1_00101; bus.PC = 32'h5008; step();
    idle_inputs();
    #1 peek("drop_epc", bus.EPC_out, 32'h5008);
    bus.eret = 1'b1; step(); idle_inputs();
    bus.we = 1'b1; bus.A = 5'd14; bus.DIn = 32'hDEAD_BEEF; step(); idle_inputs();
    #1 peek("mtc0_epc", bus.EPC_out, 32'hDEAD_BEEC);

    // nested requests suppressed while in handler
    bus.exc_in = 6'b1_00100; bus.PC = 32'h6000; step(); idle_inputs();
    bus.exc_in = 6'b1_01100; bus.HWInt = 6'b111111; bus.PC = 32'h7000; bus.A = 5'd15;
    #1 peek("nest_intreq", 32'(bus.IntReq), 32'h0);
    peek("prid", bus.DOut, PRID);
    step(); idle_inputs();
    #1 peek("nest_epc", bus.EPC_out, 32'h6000);
    step();

    // reset wins over a same-cycle request
    bus.exc_in = 6'b1_01010; bus.PC = 32'h8000; reset = 1'b1; step(); idle_inputs();
    #1 peek("rst_win_epc", bus.EPC_out, 32'h0);
    peek("rst_win_exl", 32'(bus.state_dbg), 32'h0);
    step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      bus.we     = ($urandom_range(0, 3) == 0);
      bus.eret   = ($urandom_range(0, 5) == 0);
      bus.exc_in = ($urandom_range(0, 7) == 0) ? {1'b1, 5'($urandom)} : {1'b0, 5'($urandom)};
      bus.HWInt  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0;
      bus.A      = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(12, 15)) : 5'($urandom);
      bus.DIn    = $urandom;
      bus.PC     = $urandom;
      bus.BD     = 1'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
